// File: rtl/tmem_xbar_pkg.sv
// ============================================================================
// Module  : tmem_xbar_pkg
// Purpose : Shared helpers for the TMEM read crossbar: a constant-evaluable
//           ceil(log2) and a slice macro for the flattened per-core and
//           per-bank buses.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef TMEM_XBAR_PKG_SV
`define TMEM_XBAR_PKG_SV

// Part-select of element idx (width w) within a flattened bus.
`define TMEM_SLICE(idx, w) ((idx)*(w)) +: (w)

package tmem_xbar_pkg;

    // ceil(log2(value)), never below 1 so that index vectors stay legal.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`endif

`default_nettype wire

// File: rtl/tmem_rr_arbiter.sv
// ============================================================================
// Module  : tmem_rr_arbiter
// Purpose : Round-robin arbiter for one TMEM bank. Picks the first requesting
//           core at or after the rotating pointer; optionally co-grants every
//           requester reading the winner's physical address.
// Ports   : clk/rst       - clock, synchronous active-high reset
//           i_req         - per-core eligible request for this bank
//           i_paddr       - per-core physical address, flattened
//           i_mergeEn     - allow same-address co-grants
//           o_gnt         - grant vector including merged cores
//           o_winner      - index of the arbitration winner
//           o_en          - bank read enable (a winner exists)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tmem_rr_arbiter
    import tmem_xbar_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int PADDR_W   = 16,
    parameter int IDX_W     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CORES-1:0]         i_req,
    input  logic [NUM_CORES*PADDR_W-1:0] i_paddr,
    input  logic                         i_mergeEn,
    output logic [NUM_CORES-1:0]         o_gnt,
    output logic [IDX_W-1:0]             o_winner,
    output logic                         o_en
);

    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_winner;
    logic               w_found;
    logic [PADDR_W-1:0] w_winAddr;

    // Rotating search: visit ptr, ptr+1, ... wrapping at NUM_CORES.
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NUM_CORES) begin
                idx = idx - NUM_CORES;
            end
            if (!w_found && i_req[IDX_W'(idx)]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        w_winAddr = '0;
        for (int j = 0; j < NUM_CORES; j++) begin
            if (IDX_W'(j) == w_winner) begin
                w_winAddr = i_paddr[`TMEM_SLICE(j, PADDR_W)];
            end
        end
    end

    always_comb begin
        o_gnt = '0;
        for (int j = 0; j < NUM_CORES; j++) begin
            if (w_found && i_req[j]) begin
                if (IDX_W'(j) == w_winner) begin
                    o_gnt[j] = 1'b1;
                end else if (i_mergeEn && (i_paddr[`TMEM_SLICE(j, PADDR_W)] == w_winAddr)) begin
                    o_gnt[j] = 1'b1;
                end
            end
        end
    end

    // Only the winner moves the pointer; merged cores do not affect fairness.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (int'(w_winner) == NUM_CORES - 1) ? '0 : w_winner + 1'b1;
        end
    end

    assign o_winner = w_winner;
    assign o_en     = w_found;

endmodule

`default_nettype wire

// File: rtl/tmem_xbar_rr.sv
// ============================================================================
// Module  : tmem_xbar_rr
// Purpose : N-core x M-bank texture-memory read crossbar. Per-bank round-robin
//           arbitration, optional same-address merging, registered grant and
//           read-data return, per-bank saturating conflict counters.
// Ports   : CLK_I, RST_I  - clock, synchronous active-high reset
//           REQ_I, ADR_I  - per-core level request and virtual address
//           GNT_O         - grant pulse, one cycle after arbitration
//           DAT_O, DVAL_O - read data and valid pulse, two cycles after
//           BRD_EN_O, BRD_ADR_O, BRD_DAT_I - bank read port (1-cycle RAM)
//           CLR_STATS_I   - clear conflict counters
//           CONFLICT_O    - per-bank conflict counts
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tmem_xbar_rr
    import tmem_xbar_pkg::*;
#(
    parameter int NUM_CORES    = 4,
    parameter int NUM_BANKS    = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int BANK_ADDR_W  = 16,
    parameter int ENABLE_MERGE = 1,
    parameter int CNT_W        = 16
) (
    input  logic                             CLK_I,
    input  logic                             RST_I,
    input  logic [NUM_CORES-1:0]             REQ_I,
    input  logic [NUM_CORES*ADDR_W-1:0]      ADR_I,
    output logic [NUM_CORES-1:0]             GNT_O,
    output logic [NUM_CORES*DATA_W-1:0]      DAT_O,
    output logic [NUM_CORES-1:0]             DVAL_O,
    output logic [NUM_BANKS-1:0]             BRD_EN_O,
    output logic [NUM_BANKS*BANK_ADDR_W-1:0] BRD_ADR_O,
    input  logic [NUM_BANKS*DATA_W-1:0]      BRD_DAT_I,
    input  logic                             CLR_STATS_I,
    output logic [NUM_BANKS*CNT_W-1:0]       CONFLICT_O
);

    localparam int              c_BANK_SEL_W = clog2(NUM_BANKS);
    localparam int              c_CORE_IDX_W = clog2(NUM_CORES);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;

    logic [NUM_CORES-1:0]             w_elig;
    logic [c_BANK_SEL_W-1:0]          w_bank [NUM_CORES];
    logic [NUM_CORES*BANK_ADDR_W-1:0] w_paddr;
    logic [NUM_CORES-1:0]             w_bankGnt [NUM_BANKS];
    logic [c_CORE_IDX_W-1:0]          w_bankWin [NUM_BANKS];
    logic [DATA_W-1:0]                w_bankDat [NUM_BANKS];
    logic [NUM_CORES-1:0]             w_coreGnt;
    logic                             w_unusedAdr;

    logic [NUM_CORES-1:0]             r_gnt;
    logic [NUM_CORES-1:0]             r_dval;
    logic [NUM_CORES*DATA_W-1:0]      r_dat;
    logic [c_BANK_SEL_W-1:0]          r_gntBank [NUM_CORES];

    // r_gnt doubles as the one-cycle mask: a core is ineligible exactly in
    // the cycle its GNT_O is visible. Nothing is eligible during reset.
    assign w_elig      = RST_I ? '0 : (REQ_I & ~r_gnt);
    assign w_unusedAdr = ^ADR_I;

    // Low address bits select the bank; the next BANK_ADDR_W bits are the
    // in-bank address (upper bits are dropped).
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_decode
        assign w_bank[i] = ADR_I[(i*ADDR_W) +: c_BANK_SEL_W];
        assign w_paddr[`TMEM_SLICE(i, BANK_ADDR_W)] =
            ADR_I[(i*ADDR_W + c_BANK_SEL_W) +: BANK_ADDR_W];
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [NUM_CORES-1:0]   w_req;
        logic                   w_en;
        logic [BANK_ADDR_W-1:0] w_adr;
        logic [CNT_W-1:0]       r_cnt;

        always_comb begin
            w_req = '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                w_req[i] = w_elig[i] && (w_bank[i] == c_BANK_SEL_W'(b));
            end
        end

        tmem_rr_arbiter #(
            .NUM_CORES (NUM_CORES),
            .PADDR_W   (BANK_ADDR_W),
            .IDX_W     (c_CORE_IDX_W)
        ) u_arb (
            .clk       (CLK_I),
            .rst       (RST_I),
            .i_req     (w_req),
            .i_paddr   (w_paddr),
            .i_mergeEn (ENABLE_MERGE != 0),
            .o_gnt     (w_bankGnt[b]),
            .o_winner  (w_bankWin[b]),
            .o_en      (w_en)
        );

        always_comb begin
            w_adr = '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_en && (c_CORE_IDX_W'(i) == w_bankWin[b])) begin
                    w_adr = w_paddr[`TMEM_SLICE(i, BANK_ADDR_W)];
                end
            end
        end

        // A conflict cycle is any cycle leaving an eligible request ungranted.
        always_ff @(posedge CLK_I) begin
            if (RST_I || CLR_STATS_I) begin
                r_cnt <= '0;
            end else if ((|(w_req & ~w_bankGnt[b])) && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_bankDat[b]                          = BRD_DAT_I[`TMEM_SLICE(b, DATA_W)];
        assign BRD_EN_O[b]                           = w_en;
        assign BRD_ADR_O[`TMEM_SLICE(b, BANK_ADDR_W)] = w_adr;
        assign CONFLICT_O[`TMEM_SLICE(b, CNT_W)]      = RST_I ? '0 : r_cnt;
    end

    // Each core targets a single bank, so OR-ing the bank grants is exact.
    always_comb begin
        w_coreGnt = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_coreGnt = w_coreGnt | w_bankGnt[b];
        end
    end

    // Remember which bank served each grant so the returning data (one cycle
    // later) is steered from the right bank even if ADR_I has since changed.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_gnt  <= '0;
            r_dval <= '0;
            r_dat  <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_gntBank[i] <= '0;
            end
        end else begin
            r_gnt  <= w_coreGnt;
            r_dval <= r_gnt;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_coreGnt[i]) begin
                    r_gntBank[i] <= w_bank[i];
                end
                if (r_gnt[i]) begin
                    r_dat[`TMEM_SLICE(i, DATA_W)] <= w_bankDat[r_gntBank[i]];
                end
            end
        end
    end

    // Outputs read zero throughout a reset cycle, so an in-flight grant
    // caught by reset never becomes visible.
    assign GNT_O  = RST_I ? '0 : r_gnt;
    assign DVAL_O = RST_I ? '0 : r_dval;
    assign DAT_O  = RST_I ? '0 : r_dat;

endmodule

`default_nettype wire

// File: tb/tb_tmem_xbar_rr.sv
// ============================================================================
// Module  : tb_tmem_xbar_rr
// Purpose : Scoreboard bench for tmem_xbar_rr (4 cores, 4 banks, merge on,
//           4-bit conflict counters). Directed scenarios push expected grant
//           and data-valid events; a monitor pops and compares them.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tmem_xbar_rr;

    localparam int NC  = 4;
    localparam int NB  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BAW = 16;
    localparam int CW  = 4;

    logic              clk = 1'b0;
    logic              r_rst;
    logic [NC-1:0]     r_req;
    logic [NC*AW-1:0]  r_adr;
    logic              r_clr;
    logic [NB*DW-1:0]  r_brdDat;
    logic [NC-1:0]     w_gnt;
    logic [NC*DW-1:0]  w_dat;
    logic [NC-1:0]     w_dval;
    logic [NB-1:0]     w_brdEn;
    logic [NB*BAW-1:0] w_brdAdr;
    logic [NB*CW-1:0]  w_conflict;

    typedef struct {
        int          cyc;
        int          core;
        logic [31:0] data;
    } exp_t;

    exp_t gntQ[$];
    exp_t dvalQ[$];
    int   nChecks = 0;
    int   nErrors = 0;
    int   cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tmem_xbar_rr #(
        .NUM_CORES    (NC),
        .NUM_BANKS    (NB),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .BANK_ADDR_W  (BAW),
        .ENABLE_MERGE (1),
        .CNT_W        (CW)
    ) dut (
        .CLK_I       (clk),
        .RST_I       (r_rst),
        .REQ_I       (r_req),
        .ADR_I       (r_adr),
        .GNT_O       (w_gnt),
        .DAT_O       (w_dat),
        .DVAL_O      (w_dval),
        .BRD_EN_O    (w_brdEn),
        .BRD_ADR_O   (w_brdAdr),
        .BRD_DAT_I   (r_brdDat),
        .CLR_STATS_I (r_clr),
        .CONFLICT_O  (w_conflict)
    );

    // Bank contents: one hand-picked word, otherwise a tag of bank and address.
    function automatic logic [31:0] memData(input int b, input int a);
        if (b == 1 && a == 9) return 32'hCAFE_F00D;
        return {8'hB0 | 8'(b), 8'h00, 16'(a)};
    endfunction

    // Synchronous RAM model: data appears the cycle after the address.
    always @(posedge clk) begin
        if (r_rst) begin
            r_brdDat <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (w_brdEn[b]) r_brdDat[b*DW +: DW] <= memData(b, int'(w_brdAdr[b*BAW +: BAW]));
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int core, input logic on, input logic [31:0] a);
        r_req[core]          = on;
        r_adr[core*AW +: AW] = a;
    endtask

    task automatic expGnt(input int core, input int c);
        exp_t e;
        e.cyc = c; e.core = core; e.data = '0;
        gntQ.push_back(e);
    endtask

    task automatic expDval(input int core, input int c, input logic [31:0] d);
        exp_t e;
        e.cyc = c; e.core = core; e.data = d;
        dvalQ.push_back(e);
    endtask

    // Monitor: every observed pulse must match the next expected event.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < NC; i++) begin
            if (w_gnt[i] === 1'b1) begin
                if (gntQ.size() == 0) begin
                    nChecks++; nErrors++;
                    $display("FAIL gnt_unexpected: core %0d granted at cycle %0d, want no grant", i, cyc);
                end else begin
                    e = gntQ.pop_front();
                    check("gnt_core", i, e.core);
                    check("gnt_cycle", cyc, e.cyc);
                end
            end
            if (w_dval[i] === 1'b1) begin
                if (dvalQ.size() == 0) begin
                    nChecks++; nErrors++;
                    $display("FAIL dval_unexpected: core %0d valid at cycle %0d, want no valid", i, cyc);
                end else begin
                    e = dvalQ.pop_front();
                    check("dval_core", i, e.core);
                    check("dval_cycle", cyc, e.cyc);
                    check("dval_data", w_dat[i*DW +: DW], e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        r_rst = 1'b1; r_req = '0; r_adr = '0; r_clr = 1'b0;
        tick(); tick();
        r_rst = 1'b0;
        #1;
        check("rst_gnt", w_gnt, 0);
        check("rst_dval", w_dval, 0);
        check("rst_dat", w_dat, 0);
        check("rst_brdEn", w_brdEn, 0);
        check("rst_brdAdr", w_brdAdr, 0);
        check("rst_conflict", w_conflict, 0);

        // Single read: core 2 -> bank 1, physical 0x9.
        tick(); t0 = cyc;
        setReq(2, 1'b1, 32'h25);
        expGnt(2, t0 + 1);
        expDval(2, t0 + 2, 32'hCAFE_F00D);
        #1;
        check("single_brdEn", w_brdEn, 4'b0010);
        check("single_brdAdr1", w_brdAdr[1*BAW +: BAW], 16'h0009);
        tick(); setReq(2, 1'b0, 32'h0);
        repeat (3) tick();

        // Round robin on bank 0 from reset, distinct addresses.
        r_rst = 1'b1; tick(); r_rst = 1'b0;
        t0 = cyc;
        for (int i = 0; i < NC; i++) setReq(i, 1'b1, 32'(i * 4));
        for (int k = 0; k < 8; k++) begin
            expGnt(k % 4, t0 + 1 + k);
            expDval(k % 4, t0 + 2 + k, memData(0, k % 4));
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("rr_conflict0", w_conflict[0 +: CW], k);
            if (k == 8) r_req = '0;
        end
        repeat (3) tick();

        // Merge: cores 1 and 3 read 0x40 together.
        r_clr = 1'b1; tick(); r_clr = 1'b0;
        check("clr_conflict0", w_conflict[0 +: CW], 0);
        t0 = cyc;
        setReq(1, 1'b1, 32'h40);
        setReq(3, 1'b1, 32'h40);
        expGnt(1, t0 + 1); expGnt(3, t0 + 1);
        expDval(1, t0 + 2, memData(0, 16'h10));
        expDval(3, t0 + 2, memData(0, 16'h10));
        #1;
        check("merge_brdEn", w_brdEn, 4'b0001);
        check("merge_brdAdr0", w_brdAdr[0 +: BAW], 16'h0010);
        tick(); r_req = '0;
        check("merge_conflict0", w_conflict[0 +: CW], 0);
        repeat (3) tick();

        // Parallel banks: addresses 1..4 hit banks 1,2,3,0.
        tick(); t0 = cyc;
        for (int i = 0; i < NC; i++) setReq(i, 1'b1, 32'(i + 1));
        for (int i = 0; i < NC; i++) begin
            expGnt(i, t0 + 1);
            expDval(i, t0 + 2, memData((i + 1) % 4, (i + 1) / 4));
        end
        #1;
        check("par_brdEn", w_brdEn, 4'b1111);
        check("par_brdAdr", w_brdAdr, 64'h0000_0000_0000_0001);
        tick(); r_req = '0;
        repeat (3) tick();

        // Back-to-back: core 0 alone, held high -> one grant every 2 cycles.
        tick(); t0 = cyc;
        setReq(0, 1'b1, 32'h08);
        for (int k = 0; k < 3; k++) begin
            expGnt(0, t0 + 1 + 2 * k);
            expDval(0, t0 + 2 + 2 * k, memData(0, 2));
        end
        tick(); check("mask_brdEn_masked", w_brdEn[0], 1'b0);
        tick(); check("mask_brdEn_again", w_brdEn[0], 1'b1);
        repeat (4) tick();
        r_req = '0;
        repeat (3) tick();

        // Reset mid-operation: request at T0, reset at T1 -> nothing emerges.
        tick(); t0 = cyc;
        setReq(1, 1'b1, 32'h05);
        #1; check("rstmid_brdEn", w_brdEn, 4'b0010);
        tick(); r_rst = 1'b1; r_req = '0;
        #1; check("rstmid_gnt", w_gnt, 0);
        tick(); r_rst = 1'b0;
        // Pointer must be back at 0: core 0 beats core 2 on bank 1.
        t0 = cyc;
        setReq(0, 1'b1, 32'h01);
        setReq(2, 1'b1, 32'h05);
        expGnt(0, t0 + 1);
        expDval(0, t0 + 2, memData(1, 0));
        #1;
        check("rstmid_dval", w_dval, 0);
        check("rstptr_brdAdr1", w_brdAdr[1*BAW +: BAW], 16'h0000);
        tick(); r_req = '0;
        repeat (3) tick();

        // Saturation: three cores contend on bank 2 for 21 cycles.
        tick(); t0 = cyc;
        for (int i = 0; i < 3; i++) setReq(i, 1'b1, 32'(i * 4 + 2));
        for (int k = 0; k <= 20; k++) begin
            expGnt(k % 3, t0 + 1 + k);
            expDval(k % 3, t0 + 2 + k, memData(2, k % 3));
        end
        repeat (14) tick();
        check("sat_conflict2_14", w_conflict[2*CW +: CW], 14);
        repeat (5) tick();
        check("sat_conflict2_19", w_conflict[2*CW +: CW], 15);
        tick();
        check("sat_conflict2_20", w_conflict[2*CW +: CW], 15);
        r_clr = 1'b1;
        tick();
        r_clr = 1'b0; r_req = '0;
        check("sat_clr_conflict2", w_conflict[2*CW +: CW], 0);
        repeat (4) tick();

        check("gnt_queue_empty", gntQ.size(), 0);
        check("dval_queue_empty", dvalQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

`default_nettype wire
